// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: req/gnt/rvalid data-SRAM port between the MEM stage and memory.
// The master side issues requests; the slave side grants and returns read data.
interface mem_stage_lsu_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req;
    logic                  wr;
    logic [DATA_W/8-1:0]   be;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, wr, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, wr, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM stage with a one-entry skid register, data-SRAM port and load extension.
// Define MEM_STAGE_MISALIGN_EXC_EN to trap misaligned accesses instead of forcing alignment.
module mem_stage_lsu #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int PC_W   = 32,
    parameter int RF_AW  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [PC_W-1:0]   ex_pc_i,
    input  logic [3:0]        ex_lsu_op_i,
    input  logic [DATA_W-1:0] ex_result_i,
    input  logic [DATA_W-1:0] ex_sdata_i,
    input  logic              ex_rf_we_i,
    input  logic [RF_AW-1:0]  ex_rf_waddr_i,
    mem_stage_lsu_if.master   dmem,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [PC_W-1:0]   wb_pc_o,
    output logic              wb_rf_we_o,
    output logic [RF_AW-1:0]  wb_rf_waddr_o,
    output logic [DATA_W-1:0] wb_rf_wdata_o,
    output logic              fw_we_o,
    output logic [RF_AW-1:0]  fw_waddr_o,
    output logic [DATA_W-1:0] fw_wdata_o,
    output logic              fw_pending_o,
`ifdef MEM_STAGE_MISALIGN_EXC_EN
    output logic              exc_adel_o,
    output logic              exc_ades_o,
    output logic [ADDR_W-1:0] exc_badvaddr_o,
`endif
    output logic              stallreq_o
);
    localparam int NB = DATA_W / 8;
    localparam int LW = $clog2(NB);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_e;

    state_e state_q, state_d;
    logic   valid_q, valid_d;
    logic   cap, ld_done;

    logic [PC_W-1:0]   pc_q;
    logic              rf_we_q;
    logic [RF_AW-1:0]  waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LW-1:0]     lane_q;
    logic [1:0]        size_q;
    logic              ld_q;
    logic              uns_q;
    logic [NB-1:0]     be_q;
    logic [DATA_W-1:0] sdata_q;

    logic              dec_mem, dec_ld, dec_uns;
    logic [1:0]        dec_size;
    logic [LW-1:0]     ex_lane, szm, lane_al;
    logic [NB-1:0]     szb;
    logic [DATA_W-1:0] rep;
    logic              mis;
    logic [DATA_W-1:0] sh, ext;

    // Opcodes that need a 64-bit datapath decode as NONE on a 32-bit build.
    always_comb begin
        dec_mem  = 1'b0;
        dec_ld   = 1'b0;
        dec_uns  = 1'b0;
        dec_size = 2'd0;
        unique case (ex_lsu_op_i)
            4'd1: begin dec_mem = 1'b1; dec_ld = 1'b1; end
            4'd2: begin dec_mem = 1'b1; dec_ld = 1'b1; dec_uns = 1'b1; end
            4'd3: begin dec_mem = 1'b1; dec_ld = 1'b1; dec_size = 2'd1; end
            4'd4: begin
                dec_mem  = 1'b1;
                dec_ld   = 1'b1;
                dec_uns  = 1'b1;
                dec_size = 2'd1;
            end
            4'd5: begin dec_mem = 1'b1; dec_ld = 1'b1; dec_size = 2'd2; end
            4'd6: begin dec_mem = 1'b1; end
            4'd7: begin dec_mem = 1'b1; dec_size = 2'd1; end
            4'd8: begin dec_mem = 1'b1; dec_size = 2'd2; end
            4'd9: if (DATA_W == 64) begin
                dec_mem  = 1'b1;
                dec_ld   = 1'b1;
                dec_uns  = 1'b1;
                dec_size = 2'd2;
            end
            4'd10: if (DATA_W == 64) begin
                dec_mem  = 1'b1;
                dec_ld   = 1'b1;
                dec_size = 2'd3;
            end
            4'd11: if (DATA_W == 64) begin
                dec_mem  = 1'b1;
                dec_size = 2'd3;
            end
            default: ;
        endcase
    end

    always_comb begin
        szm = '0;
        szb = '1;
        rep = ex_sdata_i;
        unique case (dec_size)
            2'd0: begin
                szb = NB'(1);
                rep = {NB{ex_sdata_i[7:0]}};
            end
            2'd1: begin
                szm = LW'(1);
                szb = NB'(3);
                rep = {(NB/2){ex_sdata_i[15:0]}};
            end
            2'd2: begin
                szm = LW'(3);
                szb = NB'(15);
                rep = {(NB/4){ex_sdata_i[31:0]}};
            end
            default: szm = LW'(7);
        endcase
    end

    assign ex_lane = ex_result_i[LW-1:0];
    assign lane_al = ex_lane & ~szm;

`ifdef MEM_STAGE_MISALIGN_EXC_EN
    assign mis = dec_mem & (|(ex_lane & szm));
`else
    assign mis = 1'b0;
`endif

    assign wb_valid_o   = valid_q & (state_q == S_DONE);
    assign ex_ready_o   = (state_q != S_DRAIN)
                        & (~valid_q | (wb_valid_o & wb_ready_i));
    assign stallreq_o   = (state_q == S_REQ) | (state_q == S_WAIT)
                        | (state_q == S_DRAIN);
    assign fw_pending_o = valid_q & (state_q != S_DONE);

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        ld_done = 1'b0;
        cap     = ex_valid_i & ex_ready_o & ~flush_i;
        unique case (state_q)
            S_IDLE: begin
                if (cap) begin
                    state_d = (dec_mem & ~mis) ? S_REQ : S_DONE;
                    valid_d = 1'b1;
                end
            end
            S_REQ: begin
                if (flush_i) begin
                    state_d = (dmem.gnt & ld_q) ? S_DRAIN : S_IDLE;
                    valid_d = 1'b0;
                end else if (dmem.gnt) begin
                    state_d = ld_q ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    state_d = dmem.rvalid ? S_IDLE : S_DRAIN;
                    valid_d = 1'b0;
                end else if (dmem.rvalid) begin
                    state_d = S_DONE;
                    ld_done = 1'b1;
                end
            end
            S_DONE: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else if (wb_ready_i) begin
                    if (cap) begin
                        state_d = (dec_mem & ~mis) ? S_REQ : S_DONE;
                    end else begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                if (dmem.rvalid) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    // Read data arrives lane-aligned; shift the addressed lane down first.
    assign sh = dmem.rdata >> {lane_q, 3'b000};

    always_comb begin
        ext = sh;
        unique case (size_q)
            2'd0: ext = uns_q ? DATA_W'(sh[7:0])  : DATA_W'($signed(sh[7:0]));
            2'd1: ext = uns_q ? DATA_W'(sh[15:0]) : DATA_W'($signed(sh[15:0]));
            2'd2: ext = uns_q ? DATA_W'(sh[31:0]) : DATA_W'($signed(sh[31:0]));
            default: ext = sh;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            rf_we_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            ld_q    <= 1'b0;
            uns_q   <= 1'b0;
            be_q    <= '0;
            sdata_q <= '0;
        end else if (cap) begin
            pc_q    <= ex_pc_i;
            rf_we_q <= ex_rf_we_i & ~mis;
            waddr_q <= ex_rf_waddr_i;
            wdata_q <= ex_result_i;
            addr_q  <= ADDR_W'(ex_result_i);
            lane_q  <= lane_al;
            size_q  <= dec_size;
            ld_q    <= dec_ld;
            uns_q   <= dec_uns;
            be_q    <= szb << lane_al;
            sdata_q <= rep;
        end else if (ld_done) begin
            wdata_q <= ext;
        end
    end

    assign dmem.req   = (state_q == S_REQ);
    assign dmem.wr    = dmem.req & ~ld_q;
    assign dmem.be    = dmem.req ? (ld_q ? '1 : be_q) : '0;
    assign dmem.addr  = dmem.req ? {addr_q[ADDR_W-1:LW], {LW{1'b0}}} : '0;
    assign dmem.wdata = dmem.wr ? sdata_q : '0;

    assign wb_pc_o       = pc_q;
    assign wb_rf_we_o    = rf_we_q;
    assign wb_rf_waddr_o = waddr_q;
    assign wb_rf_wdata_o = wdata_q;

    assign fw_we_o    = valid_q & rf_we_q;
    assign fw_waddr_o = valid_q ? waddr_q : '0;
    assign fw_wdata_o = valid_q ? wdata_q : '0;

`ifdef MEM_STAGE_MISALIGN_EXC_EN
    logic              adel_q, ades_q;
    logic [ADDR_W-1:0] badv_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adel_q <= 1'b0;
            ades_q <= 1'b0;
            badv_q <= '0;
        end else if (cap) begin
            adel_q <= mis & dec_ld;
            ades_q <= mis & ~dec_ld;
            badv_q <= ADDR_W'(ex_result_i);
        end
    end

    assign exc_adel_o     = wb_valid_o & adel_q;
    assign exc_ades_o     = wb_valid_o & ades_q;
    assign exc_badvaddr_o = (exc_adel_o | exc_ades_o) ? badv_q : '0;
`endif
endmodule
